ttc_trig_decoder: RTL and testbench
===================================

// Module: ttc_trig_decoder
// PURPOSE
// Front end of the SRU trigger path. Converts raw TTC trigger inputs into single-cycle
// l0/l1/l2a/l2r strobes on gclk_40m and drives the trigger sequence checker directly.
// Decodes the TTCrx addressed-message bus into L2 accept/reject and latches BCID/orbit.
// Counts and flags malformed messages for DAQ status readout.
// PARAMETERS
// L0_GUARD     8   cycles after an l0 strobe during which further l0_in edges are dropped
// MSG_TIMEOUT  40  max cycles between consecutive words of one L2a message (1 us)
// PORTS
// gclk_40m     in   1   system clock, 40 MHz
// reset_n      in   1   asynchronous reset, active low
// l0_in        in   1   raw L0 level, asynchronous to gclk_40m
// l1a_in       in   1   raw TTC channel-A L1 accept level, asynchronous
// msg_strb     in   1   TTCrx message word valid, synchronous, 1 cycle per word
// msg_hdr      in   4   message word header: 3=L2a head, 4=L2r, 7=L2a data, others=ignored
// msg_data     in   12  message word payload
// err_clr      in   1   synchronous clear of msg_err and msg_err_cnt
// l0           out  1   L0 strobe, 1 cycle
// l1           out  1   L1 strobe, 1 cycle
// l2a          out  1   L2 accept strobe, 1 cycle
// l2r          out  1   L2 reject strobe, 1 cycle
// bcid         out  12  bunch-crossing ID of last complete L2a
// orbit        out  24  orbit ID of last complete L2a
// msg_err      out  3   sticky: [0] timeout, [1] message interrupted, [2] orphan data word
// msg_err_cnt  out  8   count of error events, saturates at 8'hFF
// BEHAVIOUR
// - Reset (reset_n=0, async): all outputs 0, FSM IDLE, guard counter 0, sync flops 0.
// - l0_in/l1a_in: each passes a 2-FF synchroniser plus an edge register; a rising edge
//   gives a 1-cycle strobe on the 3rd gclk_40m edge after the first edge sampling it high.
//   Level held high -> exactly one strobe.
// - l0 guard: after an l0 strobe a counter loads L0_GUARD; edges seen while it is
//   nonzero are dropped (no strobe, no error). l1 has no guard.
// - l0 and l1 strobes are independent and may assert in the same cycle.
// - Message FSM (msg_hdr only sampled when msg_strb=1):
//   IDLE: hdr3 -> capture data as bcid_tmp, go W1. hdr4 -> l2r next cycle, stay IDLE.
//         hdr7 -> msg_err[2], stay IDLE. Other headers ignored.
//   W1:   hdr7 -> orbit_tmp[23:12]=data, go W2.
//   W2:   hdr7 -> orbit_tmp[11:0]=data, go DONE.
//   DONE: bcid<=bcid_tmp, orbit<=orbit_tmp, l2a=1 this cycle, go IDLE.
//         l2a is high the 2nd cycle after the final word's strobe cycle.
//         A strobe arriving in DONE is processed as in IDLE.
//   W1/W2, hdr3 -> msg_err[1], discard partial, restart W1 with the new bcid_tmp.
//   W1/W2, hdr4 -> msg_err[1], discard partial, l2r next cycle, go IDLE.
//   W1/W2, word timer > MSG_TIMEOUT with no strobe -> msg_err[0], go IDLE, no l2a/l2r.
//   The word timer clears on every accepted word.
// - bcid/orbit change only in DONE; aborted messages never modify them.
// - Each error event sets its msg_err bit and increments msg_err_cnt by 1 (saturating).
//   Simultaneous err_clr wins over the increment.
// - l2a and l2r never assert in the same cycle.
// - Reset mid-message: FSM to IDLE, no strobe emitted after release.
// TESTING
// - l0_in high 5 cycles, then l1a_in high 3 cycles after 100 cycles -> one l0 and one l1
//   pulse, each 3 cycles after its input edge.
// - Two l0_in edges 4 cycles apart, L0_GUARD=8 -> one l0 pulse; edges 12 cycles apart
//   -> two pulses.
// - Words {3,0xABC},{7,0x123},{7,0x456} -> l2a 2 cycles after last word,
//   bcid=0xABC, orbit=0x123456.
// - {3,0x001},{7,0x002}, then 41 idle cycles -> msg_err=3'b001, msg_err_cnt=1,
//   no l2a, bcid unchanged.
// - Mid-message {4,x} -> msg_err[1] set, one l2r pulse. Lone {7,x} in IDLE -> msg_err[2];
//   err_clr -> all zero.
// - Assert reset_n=0 while in W2 -> outputs 0 immediately; no l2a after release.

Source files
------------

// File: rtl/ttc_trig_decoder.sv
// ttc_trig_decoder
// Front end of the SRU trigger path. Synchronises the raw L0 and L1 TTC levels into
// single-cycle strobes, decodes the TTCrx addressed-message bus into L2 accept/reject
// strobes, latches BCID/orbit of complete L2a messages and keeps sticky error status.

module ttc_trig_decoder #(
    parameter int unsigned L0_GUARD    = 8,
    parameter int unsigned MSG_TIMEOUT = 40
) (
    input  logic        gclk_40m,
    input  logic        reset_n,
    input  logic        l0_in,
    input  logic        l1a_in,
    input  logic        msg_strb,
    input  logic [3:0]  msg_hdr,
    input  logic [11:0] msg_data,
    input  logic        err_clr,
    output logic        l0,
    output logic        l1,
    output logic        l2a,
    output logic        l2r,
    output logic [11:0] bcid,
    output logic [23:0] orbit,
    output logic [2:0]  msg_err,
    output logic [7:0]  msg_err_cnt
);

    localparam logic [7:0] GUARD_LOAD  = 8'(L0_GUARD);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MSG_TIMEOUT);

    localparam logic [3:0] HDR_L2A_HEAD = 4'd3;
    localparam logic [3:0] HDR_L2R      = 4'd4;
    localparam logic [3:0] HDR_L2A_DATA = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_DONE = 2'd3
    } msg_state_t;

    // Saturating 8-bit increment for the error event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

    // ------------------------------------------------------------------
    // Trigger level synchronisers and edge detection
    // ------------------------------------------------------------------
    logic       l0_meta_r, l0_sync_r, l0_prev_r;
    logic       l1_meta_r, l1_sync_r, l1_prev_r;
    logic [7:0] l0_guard_r;
    logic       l0_fire_s;
    logic       l1_fire_s;

    // An l0 edge only produces a strobe once the guard window has expired.
    assign l0_fire_s = l0_sync_r & ~l0_prev_r & (l0_guard_r == 8'd0);
    assign l1_fire_s = l1_sync_r & ~l1_prev_r;

    // Two-stage synchronisers plus previous-value registers for edge detection.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            l0_meta_r <= 1'b0;
            l0_sync_r <= 1'b0;
            l0_prev_r <= 1'b0;
            l1_meta_r <= 1'b0;
            l1_sync_r <= 1'b0;
            l1_prev_r <= 1'b0;
        end else begin
            l0_meta_r <= l0_in;
            l0_sync_r <= l0_meta_r;
            l0_prev_r <= l0_sync_r;
            l1_meta_r <= l1a_in;
            l1_sync_r <= l1_meta_r;
            l1_prev_r <= l1_sync_r;
        end
    end

    // L0 guard counter: reload on every emitted l0 strobe, count down to zero.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            l0_guard_r <= 8'd0;
        end else if (l0_fire_s) begin
            l0_guard_r <= GUARD_LOAD;
        end else if (l0_guard_r != 8'd0) begin
            l0_guard_r <= l0_guard_r - 8'd1;
        end else begin
            l0_guard_r <= 8'd0;
        end
    end

    // Registered L0/L1 strobes.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            l0 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            l0 <= l0_fire_s;
            l1 <= l1_fire_s;
        end
    end

    // ------------------------------------------------------------------
    // Message decoder FSM
    // ------------------------------------------------------------------
    msg_state_t  state_r, state_nxt_s;
    logic [11:0] bcid_tmp_r, bcid_tmp_nxt_s;
    logic [23:0] orbit_tmp_r, orbit_tmp_nxt_s;
    logic [7:0]  timer_r, timer_nxt_s;
    logic        l2r_pend_r, l2r_pend_nxt_s;
    logic        l2a_nxt_s, l2r_nxt_s, l2r_req_s, commit_s;
    logic [2:0]  err_evt_s;
    logic        hdr3_s, hdr4_s, hdr7_s;

    assign hdr3_s = msg_strb && (msg_hdr == HDR_L2A_HEAD);
    assign hdr4_s = msg_strb && (msg_hdr == HDR_L2R);
    assign hdr7_s = msg_strb && (msg_hdr == HDR_L2A_DATA);

    // Next-state, scratch registers, strobe requests and error events.
    always_comb begin
        state_nxt_s     = state_r;
        bcid_tmp_nxt_s  = bcid_tmp_r;
        orbit_tmp_nxt_s = orbit_tmp_r;
        timer_nxt_s     = timer_r;
        l2a_nxt_s       = 1'b0;
        l2r_req_s       = 1'b0;
        commit_s        = 1'b0;
        err_evt_s       = 3'b000;

        case (state_r)
            S_IDLE, S_DONE: begin
                if (state_r == S_DONE) begin
                    commit_s    = 1'b1;
                    l2a_nxt_s   = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
                // A word landing in DONE is handled exactly as in IDLE.
                if (hdr3_s) begin
                    bcid_tmp_nxt_s = msg_data;
                    timer_nxt_s    = 8'd0;
                    state_nxt_s    = S_W1;
                end else if (hdr4_s) begin
                    l2r_req_s = 1'b1;
                end else if (hdr7_s) begin
                    err_evt_s[2] = 1'b1;
                end else begin
                    timer_nxt_s = 8'd0;
                end
            end
            S_W1, S_W2: begin
                if (hdr7_s) begin
                    timer_nxt_s = 8'd0;
                    if (state_r == S_W1) begin
                        orbit_tmp_nxt_s[23:12] = msg_data;
                        state_nxt_s            = S_W2;
                    end else begin
                        orbit_tmp_nxt_s[11:0] = msg_data;
                        state_nxt_s           = S_DONE;
                    end
                end else if (hdr3_s) begin
                    // New head interrupts the message: restart with the new BCID.
                    err_evt_s[1]   = 1'b1;
                    bcid_tmp_nxt_s = msg_data;
                    timer_nxt_s    = 8'd0;
                    state_nxt_s    = S_W1;
                end else if (hdr4_s) begin
                    err_evt_s[1] = 1'b1;
                    l2r_req_s    = 1'b1;
                    timer_nxt_s  = 8'd0;
                    state_nxt_s  = S_IDLE;
                end else if (timer_r > TIMEOUT_LIM) begin
                    err_evt_s[0] = 1'b1;
                    timer_nxt_s  = 8'd0;
                    state_nxt_s  = S_IDLE;
                end else begin
                    timer_nxt_s = timer_r + 8'd1;
                end
            end
            default: begin
                timer_nxt_s = 8'd0;
                state_nxt_s = S_IDLE;
            end
        endcase

        // An l2r requested in the same cycle as an l2a is deferred by one cycle.
        l2r_nxt_s      = (l2r_req_s && !l2a_nxt_s) || l2r_pend_r;
        l2r_pend_nxt_s = l2r_req_s && l2a_nxt_s;
    end

    // FSM state and message scratch registers.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            bcid_tmp_r  <= 12'd0;
            orbit_tmp_r <= 24'd0;
            timer_r     <= 8'd0;
            l2r_pend_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bcid_tmp_r  <= bcid_tmp_nxt_s;
            orbit_tmp_r <= orbit_tmp_nxt_s;
            timer_r     <= timer_nxt_s;
            l2r_pend_r  <= l2r_pend_nxt_s;
        end
    end

    // L2 strobes and BCID/orbit, updated only by a completed L2a message.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            l2a   <= 1'b0;
            l2r   <= 1'b0;
            bcid  <= 12'd0;
            orbit <= 24'd0;
        end else begin
            l2a <= l2a_nxt_s;
            l2r <= l2r_nxt_s;
            if (commit_s) begin
                bcid  <= bcid_tmp_r;
                orbit <= orbit_tmp_r;
            end else begin
                bcid  <= bcid;
                orbit <= orbit;
            end
        end
    end

    // Sticky error flags and saturating event counter; clear has priority.
    always_ff @(posedge gclk_40m or negedge reset_n) begin
        if (!reset_n) begin
            msg_err     <= 3'b000;
            msg_err_cnt <= 8'd0;
        end else if (err_clr) begin
            msg_err     <= 3'b000;
            msg_err_cnt <= 8'd0;
        end else if (err_evt_s != 3'b000) begin
            msg_err     <= msg_err | err_evt_s;
            msg_err_cnt <= sat_inc8(msg_err_cnt);
        end else begin
            msg_err     <= msg_err;
            msg_err_cnt <= msg_err_cnt;
        end
    end

endmodule

// File: tb/tb_ttc_trig_decoder.sv
// tb_ttc_trig_decoder
// Directed bench for the TTC trigger decoder: strobe latency, l0 guard window,
// L2a/L2r message decoding, timeout/interrupt/orphan errors and reset mid-message.
`timescale 1ns/1ps

module tb_ttc_trig_decoder;

    logic        gclk_40m;
    logic        reset_n;
    logic        l0_in, l1a_in, msg_strb, err_clr;
    logic [3:0]  msg_hdr;
    logic [11:0] msg_data;
    logic        l0, l1, l2a, l2r;
    logic [11:0] bcid;
    logic [23:0] orbit;
    logic [2:0]  msg_err;
    logic [7:0]  msg_err_cnt;

    int checks;
    int errors;
    int cyc;
    int l0_cnt, l1_cnt, l2a_cnt, l2r_cnt, clash_cnt;
    int l0_last, l1_last, l2a_last, l2r_last;
    int c0, b0, b1;

    ttc_trig_decoder #(.L0_GUARD(8), .MSG_TIMEOUT(40)) dut (
        .gclk_40m    (gclk_40m),
        .reset_n     (reset_n),
        .l0_in       (l0_in),
        .l1a_in      (l1a_in),
        .msg_strb    (msg_strb),
        .msg_hdr     (msg_hdr),
        .msg_data    (msg_data),
        .err_clr     (err_clr),
        .l0          (l0),
        .l1          (l1),
        .l2a         (l2a),
        .l2r         (l2r),
        .bcid        (bcid),
        .orbit       (orbit),
        .msg_err     (msg_err),
        .msg_err_cnt (msg_err_cnt)
    );

    initial gclk_40m = 1'b0;
    always #12 gclk_40m = ~gclk_40m;

    // Cycle counter, advanced on every active edge.
    always @(posedge gclk_40m) cyc <= cyc + 1;

    // Strobe monitor sampled on the falling edge.
    always @(negedge gclk_40m) begin
        if (l0)  begin l0_cnt  = l0_cnt + 1;  l0_last  = cyc; end
        if (l1)  begin l1_cnt  = l1_cnt + 1;  l1_last  = cyc; end
        if (l2a) begin l2a_cnt = l2a_cnt + 1; l2a_last = cyc; end
        if (l2r) begin l2r_cnt = l2r_cnt + 1; l2r_last = cyc; end
        if (l2a && l2r) clash_cnt = clash_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge gclk_40m);
            #1;
        end
    endtask

    task automatic send_word(input logic [3:0] hdr, input logic [11:0] data);
        msg_strb = 1'b1;
        msg_hdr  = hdr;
        msg_data = data;
        step(1);
        msg_strb = 1'b0;
        msg_hdr  = 4'd0;
        msg_data = 12'd0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        l0_cnt = 0; l1_cnt = 0; l2a_cnt = 0; l2r_cnt = 0; clash_cnt = 0;
        l0_last = 0; l1_last = 0; l2a_last = 0; l2r_last = 0;
        reset_n = 1'b0; l0_in = 1'b0; l1a_in = 1'b0; msg_strb = 1'b0;
        err_clr = 1'b0; msg_hdr = 4'd0; msg_data = 12'd0;

        // Reset state
        step(3);
        check_val("rst_strobes", {28'd0, l0, l1, l2a, l2r}, 32'd0);
        check_val("rst_bcid", {20'd0, bcid}, 32'd0);
        check_val("rst_orbit", {8'd0, orbit}, 32'd0);
        check_val("rst_err", {21'd0, msg_err, msg_err_cnt}, 32'd0);
        reset_n = 1'b1;
        step(3);

        // l0 held 5 cycles, then l1a 100 cycles later held 3 cycles
        c0 = cyc;
        l0_in = 1'b1;
        step(5);
        l0_in = 1'b0;
        step(95);
        b0 = cyc;
        l1a_in = 1'b1;
        step(3);
        l1a_in = 1'b0;
        step(10);
        check_val("l0_count", l0_cnt, 32'd1);
        check_val("l0_latency", l0_last - c0, 32'd3);
        check_val("l1_count", l1_cnt, 32'd1);
        check_val("l1_latency", l1_last - b0, 32'd3);

        // Guard: edges 4 cycles apart -> one strobe
        b1 = l0_cnt;
        l0_in = 1'b1; step(2); l0_in = 1'b0; step(2);
        l0_in = 1'b1; step(2); l0_in = 1'b0; step(20);
        check_val("guard_4apart", l0_cnt - b1, 32'd1);
        // Guard: edges 12 cycles apart -> two strobes
        b1 = l0_cnt;
        l0_in = 1'b1; step(2); l0_in = 1'b0; step(10);
        l0_in = 1'b1; step(2); l0_in = 1'b0; step(20);
        check_val("guard_12apart", l0_cnt - b1, 32'd2);

        // Complete L2a message
        send_word(4'd3, 12'hABC);
        send_word(4'd7, 12'h123);
        c0 = cyc;
        send_word(4'd7, 12'h456);
        step(5);
        check_val("l2a_count", l2a_cnt, 32'd1);
        check_val("l2a_latency", l2a_last - c0, 32'd2);
        check_val("l2a_bcid", {20'd0, bcid}, 32'h0ABC);
        check_val("l2a_orbit", {8'd0, orbit}, 32'h0012_3456);
        check_val("l2a_noerr", {29'd0, msg_err}, 32'd0);

        // Timeout between words
        send_word(4'd3, 12'h001);
        send_word(4'd7, 12'h002);
        step(39);
        check_val("tmo_early", {29'd0, msg_err}, 32'd0);
        step(5);
        check_val("tmo_err", {29'd0, msg_err}, 32'd1);
        check_val("tmo_cnt", {24'd0, msg_err_cnt}, 32'd1);
        check_val("tmo_no_l2a", l2a_cnt, 32'd1);
        check_val("tmo_bcid", {20'd0, bcid}, 32'h0ABC);
        check_val("tmo_orbit", {8'd0, orbit}, 32'h0012_3456);
        pulse_clr();
        check_val("clr1", {21'd0, msg_err, msg_err_cnt}, 32'd0);

        // L2r interrupting a message
        b0 = l2r_cnt;
        send_word(4'd3, 12'h111);
        send_word(4'd4, 12'h000);
        step(4);
        check_val("int_err", {29'd0, msg_err}, 32'b010);
        check_val("int_cnt", {24'd0, msg_err_cnt}, 32'd1);
        check_val("int_l2r", l2r_cnt - b0, 32'd1);
        check_val("int_no_l2a", l2a_cnt, 32'd1);
        // Orphan data word in IDLE
        send_word(4'd7, 12'h555);
        step(2);
        check_val("orph_err", {29'd0, msg_err}, 32'b110);
        check_val("orph_cnt", {24'd0, msg_err_cnt}, 32'd2);
        pulse_clr();
        check_val("clr2", {21'd0, msg_err, msg_err_cnt}, 32'd0);

        // Ignored header mid-message, then new head restarts it
        send_word(4'd3, 12'hAAA);
        send_word(4'd9, 12'hFFF);
        send_word(4'd3, 12'hBBB);
        send_word(4'd7, 12'hCCC);
        send_word(4'd7, 12'hDDD);
        step(4);
        check_val("rst_msg_l2a", l2a_cnt, 32'd2);
        check_val("rst_msg_bcid", {20'd0, bcid}, 32'h0BBB);
        check_val("rst_msg_orbit", {8'd0, orbit}, 32'h00CC_CDDD);
        check_val("rst_msg_err", {21'd0, msg_err, msg_err_cnt}, {21'd0, 3'b010, 8'd1});
        pulse_clr();

        // L2r word arriving while in DONE: l2a first, l2r the following cycle
        b0 = l2r_cnt;
        send_word(4'd3, 12'h321);
        send_word(4'd7, 12'h654);
        send_word(4'd7, 12'h987);
        send_word(4'd4, 12'h000);
        step(4);
        check_val("done_l2a", l2a_cnt, 32'd3);
        check_val("done_l2r", l2r_cnt - b0, 32'd1);
        check_val("done_order", l2r_last - l2a_last, 32'd1);
        check_val("done_noerr", {21'd0, msg_err, msg_err_cnt}, 32'd0);
        check_val("no_clash", clash_cnt, 32'd0);

        // Reset asserted while in W2
        send_word(4'd3, 12'h777);
        send_word(4'd7, 12'h888);
        reset_n = 1'b0;
        #1;
        check_val("rst_w2_bcid", {20'd0, bcid}, 32'd0);
        check_val("rst_w2_orbit", {8'd0, orbit}, 32'd0);
        check_val("rst_w2_out", {25'd0, l0, l1, l2a, l2r, msg_err}, 32'd0);
        step(3);
        reset_n = 1'b1;
        step(10);
        check_val("rst_w2_no_l2a", l2a_cnt, 32'd3);
        check_val("rst_w2_bcid_hold", {20'd0, bcid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
